// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// Optional performance counters are enabled with the DMEM_ARB_PERF_EN macro.
package dmem_arb_pkg;

  typedef enum logic {
    CPU_PRI = 1'b0,
    VGA_PRI = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VGA  = 2'd2
  } owner_e;

  localparam int unsigned DEF_STARVE_LIMIT = 8;
  localparam int unsigned DEF_VGA_BURST    = 4;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Used for the starvation, burst and (with DMEM_ARB_PERF_EN) performance counters.
module dmem_arb_sat_cnt #(
  parameter int unsigned       WIDTH = 4,
  parameter logic [WIDTH-1:0]  MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the CPU load/store path and the VGA reader;
// CPU has priority until a starvation timer forces a bounded VGA burst. Macro: DMEM_ARB_PERF_EN.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned VGA_BURST    = DEF_VGA_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       perf_cpu_wait,
  output logic [31:0]       perf_vga_wait
);

  localparam int unsigned STARVE_W = cnt_width(STARVE_LIMIT);
  localparam int unsigned BURST_W  = cnt_width(VGA_BURST);

  localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_LIMIT - 1);
  localparam logic [BURST_W-1:0]  BURST_MAX   = BURST_W'(VGA_BURST);
  localparam logic [BURST_W-1:0]  BURST_LAST  = BURST_W'(VGA_BURST - 1);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;

  logic [STARVE_W-1:0] starve_cnt;
  logic [BURST_W-1:0]  burst_cnt;
  logic                starve_inc, starve_clr, starve_hit;
  logic                burst_inc, burst_clr, burst_hit;

  // Grants are held low while rst is high so nothing reaches memory during reset.
  always_comb begin
    cpu_gnt = 1'b0;
    vga_gnt = 1'b0;
    if (!rst) begin
      if (state_q == CPU_PRI) begin
        cpu_gnt = cpu_req;
        vga_gnt = vga_req & ~cpu_req;
      end else begin
        vga_gnt = vga_req;
        cpu_gnt = cpu_req & ~vga_req;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  assign mem_en    = cpu_gnt | vga_gnt;
  assign mem_we    = cpu_gnt & cpu_we;
  assign mem_addr  = cpu_gnt ? cpu_addr : (vga_gnt ? vga_addr : '0);
  assign mem_wdata = cpu_gnt ? cpu_wdata : '0;

  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      owner_d = OWN_CPU;
    end else if (vga_gnt) begin
      owner_d = OWN_VGA;
    end
  end

  // A read still in flight when reset arrives is dropped, hence the rst gating.
  assign cpu_rvalid = (owner_q == OWN_CPU) & ~rst;
  assign vga_rvalid = (owner_q == OWN_VGA) & ~rst;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign vga_rdata  = vga_rvalid ? mem_rdata : '0;

  // starve_cnt only counts in CPU_PRI and rests at 0 during a forced burst.
  assign starve_inc = (state_q == CPU_PRI) & vga_req & ~vga_gnt;
  assign starve_clr = (state_q == VGA_PRI) | vga_gnt | ~vga_req;
  assign starve_hit = starve_inc & (starve_cnt == STARVE_LAST);

  assign burst_inc  = (state_q == VGA_PRI) & vga_gnt;
  assign burst_clr  = (state_q == CPU_PRI);
  assign burst_hit  = burst_inc & (burst_cnt == BURST_LAST);

  dmem_arb_sat_cnt #(
    .WIDTH (STARVE_W),
    .MAX   (STARVE_MAX)
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (starve_clr),
    .inc_i (starve_inc),
    .cnt_o (starve_cnt)
  );

  dmem_arb_sat_cnt #(
    .WIDTH (BURST_W),
    .MAX   (BURST_MAX)
  ) u_burst_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (burst_clr),
    .inc_i (burst_inc),
    .cnt_o (burst_cnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CPU_PRI: if (starve_hit) state_d = VGA_PRI;
      VGA_PRI: if (burst_hit || !vga_req) state_d = CPU_PRI;
      default: state_d = CPU_PRI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CPU_PRI;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  dmem_arb_sat_cnt #(
    .WIDTH (32),
    .MAX   (32'hFFFF_FFFF)
  ) u_perf_cpu (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (cpu_stall),
    .cnt_o (perf_cpu_wait)
  );

  dmem_arb_sat_cnt #(
    .WIDTH (32),
    .MAX   (32'hFFFF_FFFF)
  ) u_perf_vga (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (vga_req & ~vga_gnt),
    .cnt_o (perf_vga_wait)
  );
`else
  assign perf_cpu_wait = '0;
  assign perf_vga_wait = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Table-driven bench for dmem_port_arbiter with a read-return scoreboard and a
// 1-cycle-latency memory model. Perf expectations follow DMEM_ARB_PERF_EN.
module tb_dmem_port_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

`ifdef DMEM_ARB_PERF_EN
  localparam logic [31:0] PERF_SCALE = 32'd1;
`else
  localparam logic [31:0] PERF_SCALE = 32'd0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt, vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [31:0]       perf_cpu_wait, perf_vga_wait;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_gnt       (cpu_gnt),
    .cpu_stall     (cpu_stall),
    .cpu_rvalid    (cpu_rvalid),
    .cpu_rdata     (cpu_rdata),
    .vga_req       (vga_req),
    .vga_addr      (vga_addr),
    .vga_gnt       (vga_gnt),
    .vga_rvalid    (vga_rvalid),
    .vga_rdata     (vga_rdata),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .perf_cpu_wait (perf_cpu_wait),
    .perf_vga_wait (perf_vga_wait)
  );

  // Memory the arbiter drives; the bench keeps its own expected copy in exp_mem.
  logic [DATA_W-1:0] mem_model [0:DEPTH-1];
  logic [DATA_W-1:0] exp_mem   [0:DEPTH-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  typedef struct {
    bit              rst;
    bit              c_req;
    bit              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    bit              v_req;
    logic [ADDR_W-1:0] v_addr;
    bit              e_cpu;
    bit              e_vga;
    int              reps;
    bit              chk_perf;
    logic [31:0]     e_cpu_wait;
    logic [31:0]     e_vga_wait;
  } row_t;

  typedef struct {
    bit              is_vga;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  row_t    tbl_a[$];
  row_t    tbl_b[$];
  int      n_vec  = 0;
  int      n_cmp  = 0;
  int      n_miss = 0;

  function automatic row_t mk(input bit r, input bit cr, input bit cw,
                              input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                              input bit vr, input logic [ADDR_W-1:0] va,
                              input bit ec, input bit ev, input int reps);
    row_t x;
    x.rst = r;   x.c_req = cr; x.c_we = cw; x.c_addr = ca; x.c_wdata = cd;
    x.v_req = vr; x.v_addr = va; x.e_cpu = ec; x.e_vga = ev; x.reps = reps;
    x.chk_perf = 1'b0; x.e_cpu_wait = '0; x.e_vga_wait = '0;
    return x;
  endfunction

  function automatic row_t with_perf(input row_t x, input logic [31:0] cw, input logic [31:0] vw);
    row_t y;
    y = x;
    y.chk_perf = 1'b1; y.e_cpu_wait = cw; y.e_vga_wait = vw;
    return y;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (vector %0d): got 0x%08h, want 0x%08h", name, n_vec, act, exp);
    end
  endtask

  // One clock cycle: drive after the edge, compare at the falling edge, update the model.
  task automatic apply(input row_t r);
    rd_exp_t     e;
    logic [31:0] e_addr;
    rst = r.rst; cpu_req = r.c_req; cpu_we = r.c_we; cpu_addr = r.c_addr;
    cpu_wdata = r.c_wdata; vga_req = r.v_req; vga_addr = r.v_addr;
    @(negedge clk);
    n_vec++;
    check("cpu_gnt",   32'(cpu_gnt),   32'(r.e_cpu));
    check("vga_gnt",   32'(vga_gnt),   32'(r.e_vga));
    check("cpu_stall", 32'(cpu_stall), 32'(r.c_req & ~r.e_cpu));
    check("mem_en",    32'(mem_en),    32'(r.e_cpu | r.e_vga));
    check("mem_we",    32'(mem_we),    32'(r.e_cpu & r.c_we));
    e_addr = r.e_cpu ? 32'(r.c_addr) : (r.e_vga ? 32'(r.v_addr) : 32'd0);
    check("mem_addr",  32'(mem_addr),  e_addr);
    check("mem_wdata", mem_wdata,      r.e_cpu ? r.c_wdata : 32'd0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (r.rst) begin
        check("cpu_rvalid_dropped", 32'(cpu_rvalid), 32'd0);
        check("vga_rvalid_dropped", 32'(vga_rvalid), 32'd0);
      end else begin
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(!e.is_vga));
        check("vga_rvalid", 32'(vga_rvalid), 32'(e.is_vga));
        if (e.is_vga) check("vga_rdata", vga_rdata, e.data);
        else          check("cpu_rdata", cpu_rdata, e.data);
      end
    end else begin
      check("cpu_rvalid_idle", 32'(cpu_rvalid), 32'd0);
      check("vga_rvalid_idle", 32'(vga_rvalid), 32'd0);
    end
    if (r.e_cpu && !r.c_we) sb_q.push_back('{is_vga: 1'b0, data: exp_mem[r.c_addr]});
    if (r.e_cpu &&  r.c_we) exp_mem[r.c_addr] = r.c_wdata;
    if (r.e_vga)            sb_q.push_back('{is_vga: 1'b1, data: exp_mem[r.v_addr]});
    if (r.chk_perf) begin
      check("perf_cpu_wait", perf_cpu_wait, r.e_cpu_wait);
      check("perf_vga_wait", perf_vga_wait, r.e_vga_wait);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input row_t t[$]);
    foreach (t[i]) begin
      for (int k = 0; k < t[i].reps; k++) apply(t[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_model[i] = 32'hC0DE_0000 | 32'(i);
      exp_mem[i]   = 32'hC0DE_0000 | 32'(i);
    end
    mem_model[16] = 32'hDEAD_BEEF;
    exp_mem[16]   = 32'hDEAD_BEEF;

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
    @(posedge clk);
    #1;

    //                rst cr cw addr      wdata          vr addr      ec ev reps
    tbl_a.push_back(mk(1, 0, 0, 14'h0000, 32'h0,         0, 14'h0000, 0, 0, 2));
    tbl_a.push_back(mk(0, 1, 0, 14'h0010, 32'h0,         0, 14'h0000, 1, 0, 1));
    tbl_a.push_back(mk(0, 0, 0, 14'h0000, 32'h0,         0, 14'h0000, 0, 0, 1));
    tbl_a.push_back(mk(0, 1, 1, 14'h0020, 32'h12345678,  1, 14'h0100, 1, 0, 1));
    tbl_a.push_back(mk(0, 0, 0, 14'h0000, 32'h0,         1, 14'h0100, 0, 1, 1));
    tbl_a.push_back(mk(0, 1, 0, 14'h0020, 32'h0,         0, 14'h0000, 1, 0, 1));
    tbl_a.push_back(mk(0, 0, 0, 14'h0000, 32'h0,         1, 14'h0040, 0, 1, 1));
    tbl_a.push_back(mk(0, 0, 0, 14'h0000, 32'h0,         0, 14'h0000, 0, 0, 1));

    // Starvation, forced burst, early release and release on the last burst grant.
    tbl_b.push_back(with_perf(mk(0, 1, 0, 14'h0050, 32'h0, 1, 14'h0060, 1, 0, 1), 32'd0, 32'd0));
    tbl_b.push_back(mk(0, 1, 0, 14'h0050, 32'h0,         1, 14'h0060, 1, 0, 7));
    tbl_b.push_back(mk(0, 1, 0, 14'h0050, 32'h0,         1, 14'h0060, 0, 1, 4));
    tbl_b.push_back(with_perf(mk(0, 1, 0, 14'h0050, 32'h0, 1, 14'h0060, 1, 0, 1),
                              32'd4 * PERF_SCALE, 32'd8 * PERF_SCALE));
    tbl_b.push_back(mk(0, 1, 0, 14'h0050, 32'h0,         1, 14'h0061, 1, 0, 7));
    tbl_b.push_back(mk(0, 1, 0, 14'h0050, 32'h0,         1, 14'h0061, 0, 1, 2));
    tbl_b.push_back(mk(0, 1, 0, 14'h0051, 32'h0,         0, 14'h0000, 1, 0, 1));
    tbl_b.push_back(mk(0, 1, 0, 14'h0052, 32'h0,         1, 14'h0062, 1, 0, 8));
    tbl_b.push_back(mk(0, 1, 0, 14'h0052, 32'h0,         1, 14'h0062, 0, 1, 4));
    tbl_b.push_back(mk(0, 1, 0, 14'h0053, 32'h0,         0, 14'h0000, 1, 0, 1));
    tbl_b.push_back(mk(0, 1, 0, 14'h0054, 32'h0,         1, 14'h0063, 1, 0, 8));
    tbl_b.push_back(mk(0, 1, 0, 14'h0054, 32'h0,         1, 14'h0063, 0, 1, 1));
    tbl_b.push_back(mk(0, 0, 0, 14'h0000, 32'h0,         0, 14'h0000, 0, 0, 1));

    run_table(tbl_a);

    // Reset lands the cycle after a CPU read grant: the read must never return.
    apply(mk(0, 1, 0, 14'h0010, 32'h0, 0, 14'h0000, 1, 0, 1));
    apply(mk(1, 1, 0, 14'h0050, 32'h0, 1, 14'h0060, 0, 0, 1));

    run_table(tbl_b);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
